// File: rtl/sat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_pkg                                                         |
// | Brief    : value encodings and helpers shared by the SAT variable store    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sat_pkg;

    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_FALSE = 2'b01;
    localparam logic [1:0] VAL_TRUE  = 2'b10;
    localparam logic [1:0] VAL_MARK  = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // Number of live elements after s pairing stages of an n-wide reduction.
    function automatic int stage_len(input int n, input int s);
        int len;
        len = n;
        for (int i = 0; i < s; i++) len = (len + 1) / 2;
        return len;
    endfunction

    function automatic logic [2:0] pack_val_reason(input logic [1:0] val, input logic reason);
        return {val, reason};
    endfunction

    function automatic logic is_assigned(input logic [1:0] val);
        return (val == VAL_FALSE) || (val == VAL_TRUE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/var_state_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : var_state_cell                                                  |
// | Brief    : one variable's {val, reason, lvl} register with its update rules |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module var_state_cell
    import sat_pkg::*;
#(
    parameter int WIDTH_LVL = 10
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [WIDTH_LVL+2:0] i_state,
    input  logic                 i_bkt,
    input  logic [WIDTH_LVL-1:0] i_bkt_lvl,
    input  logic                 i_imply,
    input  logic                 i_decide,
    input  logic                 i_decide_val,
    input  logic [WIDTH_LVL-1:0] i_cur_lvl,
    input  logic [2:0]           i_var_value,
    output logic [WIDTH_LVL+2:0] o_state,
    output logic                 o_imply_hit,
    output logic                 o_conflict_hit,
    output logic                 o_literal,
    output logic [WIDTH_LVL-1:0] o_lit_lvl
);

    logic [1:0]           r_val;
    logic                 r_reason;
    logic [WIDTH_LVL-1:0] r_lvl;
    logic [1:0]           w_in_val;
    logic                 w_free;

    assign w_in_val       = i_var_value[2:1];
    assign w_free         = (r_val == VAL_FREE);
    assign o_imply_hit    = i_imply && !i_wr && w_free && is_assigned(w_in_val);
    assign o_conflict_hit = i_imply && !i_wr && is_assigned(r_val) &&
                            is_assigned(w_in_val) && (w_in_val != r_val);
    // Current-level implied vars are resolved away; only decisions stay in the clause.
    assign o_literal      = (w_in_val == VAL_MARK) && ((r_lvl != i_cur_lvl) || !r_reason);
    assign o_lit_lvl      = (o_literal && (r_lvl < i_cur_lvl)) ? r_lvl : '0;
    assign o_state        = {pack_val_reason(r_val, r_reason), r_lvl};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val    <= VAL_FREE;
            r_reason <= 1'b0;
            r_lvl    <= '0;
        end else if (i_wr) begin
            r_val    <= i_state[WIDTH_LVL+2:WIDTH_LVL+1];
            r_reason <= i_state[WIDTH_LVL];
            r_lvl    <= i_state[WIDTH_LVL-1:0];
        end else if (i_bkt) begin
            if (r_lvl > i_bkt_lvl) begin
                r_val    <= VAL_FREE;
                r_reason <= 1'b0;
                r_lvl    <= '0;
            end
        end else if (o_imply_hit) begin
            r_val    <= w_in_val;
            r_reason <= i_var_value[0];
            r_lvl    <= i_cur_lvl;
        end else if (i_decide && w_free) begin
            r_val    <= i_decide_val ? VAL_TRUE : VAL_FALSE;
            r_reason <= 1'b0;
            r_lvl    <= i_cur_lvl;
        end
    end

endmodule
`default_nettype wire

// File: rtl/var_state_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : var_state_array                                                 |
// | Brief    : per-variable state store with learned-clause reduction pipeline |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module var_state_array
    import sat_pkg::*;
#(
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_LVL   = 10,
    parameter int WIDTH_C_LEN = 4,
    localparam int WIDTH_VAR_STATES = 3 + WIDTH_LVL
)
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3*NUM_VARS-1:0]                var_value_i,
    output logic [3*NUM_VARS-1:0]                var_value_o,
    input  logic [NUM_VARS-1:0]                  decide_i,
    input  logic                                 decide_val_i,
    input  logic [WIDTH_LVL-1:0]                 cur_lvl_i,
    input  logic                                 apply_imply_i,
    output logic                                 find_imply_o,
    output logic                                 find_conflict_o,
    input  logic                                 analyze_start_i,
    output logic                                 analyze_done_o,
    output logic [WIDTH_LVL-1:0]                 max_lvl_o,
    output logic [WIDTH_C_LEN-1:0]               clause_len_o,
    input  logic                                 apply_bkt_i,
    input  logic [WIDTH_LVL-1:0]                 bkt_lvl_i,
    output logic                                 busy_o,
    input  logic [NUM_VARS-1:0]                  wr_states_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o
);

    localparam int RED_STAGES = clog2(NUM_VARS);
    localparam int STEP_W     = (RED_STAGES > 0) ? clog2(RED_STAGES + 1) : 1;
    localparam logic [STEP_W-1:0] c_step_last = STEP_W'(RED_STAGES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]                  r_state, w_state_nxt;
    logic [STEP_W-1:0]           r_step, w_step_nxt;
    logic                        r_find_imply, r_find_conflict;
    logic [WIDTH_LVL-1:0]        r_max_lvl;
    logic [WIDTH_C_LEN-1:0]      r_clause_len;
    logic                        w_start_acc, w_imply_en, w_decide_en;
    logic [NUM_VARS-1:0]         w_imply_hit, w_conflict_hit, w_lit;
    logic [WIDTH_LVL-1:0]        w_lit_lvl [NUM_VARS];
    logic [WIDTH_LVL-1:0]        r_red_lvl [0:RED_STAGES][0:NUM_VARS-1];
    logic [WIDTH_LVL-1:0]        w_red_lvl [0:RED_STAGES][0:NUM_VARS-1];
    logic [WIDTH_C_LEN-1:0]      r_red_cnt [0:RED_STAGES][0:NUM_VARS-1];
    logic [WIDTH_C_LEN-1:0]      w_red_cnt [0:RED_STAGES][0:NUM_VARS-1];

    function automatic logic [WIDTH_C_LEN-1:0] sat_add(input logic [WIDTH_C_LEN-1:0] a,
                                                       input logic [WIDTH_C_LEN-1:0] b);
        logic [WIDTH_C_LEN:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH_C_LEN] ? '1 : s[WIDTH_C_LEN-1:0];
    endfunction

    // Global command priority; per-var load priority lives inside each cell.
    assign w_start_acc = analyze_start_i && !apply_bkt_i && (r_state == ST_IDLE);
    assign w_imply_en  = apply_imply_i && !apply_bkt_i && !analyze_start_i;
    assign w_decide_en = !apply_bkt_i && !analyze_start_i && !apply_imply_i;

    generate
        for (genvar k = 0; k < NUM_VARS; k++) begin : g_cell
            localparam int SOFS = (NUM_VARS - 1 - k) * WIDTH_VAR_STATES;
            logic [WIDTH_VAR_STATES-1:0] w_state;

            var_state_cell #(.WIDTH_LVL(WIDTH_LVL)) u_cell (
                .clk            (clk),
                .rst            (rst),
                .i_wr           (wr_states_i[k]),
                .i_state        (vars_states_i[SOFS +: WIDTH_VAR_STATES]),
                .i_bkt          (apply_bkt_i),
                .i_bkt_lvl      (bkt_lvl_i),
                .i_imply        (w_imply_en),
                .i_decide       (decide_i[k] && w_decide_en),
                .i_decide_val   (decide_val_i),
                .i_cur_lvl      (cur_lvl_i),
                .i_var_value    (var_value_i[(NUM_VARS-1-k)*3 +: 3]),
                .o_state        (w_state),
                .o_imply_hit    (w_imply_hit[k]),
                .o_conflict_hit (w_conflict_hit[k]),
                .o_literal      (w_lit[k]),
                .o_lit_lvl      (w_lit_lvl[k])
            );

            assign vars_states_o[SOFS +: WIDTH_VAR_STATES]    = w_state;
            assign var_value_o[(NUM_VARS-1-k)*3 +: 3]         = w_state[WIDTH_VAR_STATES-1 -: 3];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_find_imply    <= 1'b0;
            r_find_conflict <= 1'b0;
        end else if (w_imply_en) begin
            r_find_imply    <= |w_imply_hit;
            r_find_conflict <= |w_conflict_hit;
        end
    end

    // Stage 0 snapshots the cells; each later stage halves the element count.
    always_comb begin
        for (int s = 0; s <= RED_STAGES; s++) begin
            for (int j = 0; j < NUM_VARS; j++) begin
                w_red_lvl[s][j] = '0;
                w_red_cnt[s][j] = '0;
            end
        end
        for (int j = 0; j < NUM_VARS; j++) begin
            w_red_lvl[0][j] = w_lit_lvl[j];
            w_red_cnt[0][j] = WIDTH_C_LEN'(w_lit[j]);
        end
        for (int s = 1; s <= RED_STAGES; s++) begin
            for (int j = 0; j < NUM_VARS; j++) begin
                if (j < stage_len(NUM_VARS, s)) begin
                    if (2*j + 1 < stage_len(NUM_VARS, s - 1)) begin
                        w_red_lvl[s][j] = (r_red_lvl[s-1][2*j] > r_red_lvl[s-1][(2*j+1 < NUM_VARS) ? 2*j+1 : 2*j]) ?
                                          r_red_lvl[s-1][2*j] : r_red_lvl[s-1][(2*j+1 < NUM_VARS) ? 2*j+1 : 2*j];
                        w_red_cnt[s][j] = sat_add(r_red_cnt[s-1][2*j], r_red_cnt[s-1][(2*j+1 < NUM_VARS) ? 2*j+1 : 2*j]);
                    end else begin
                        w_red_lvl[s][j] = r_red_lvl[s-1][2*j];
                        w_red_cnt[s][j] = r_red_cnt[s-1][2*j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= RED_STAGES; s++) begin
                for (int j = 0; j < NUM_VARS; j++) begin
                    r_red_lvl[s][j] <= '0;
                    r_red_cnt[s][j] <= '0;
                end
            end
        end else begin
            for (int s = 0; s <= RED_STAGES; s++) begin
                for (int j = 0; j < NUM_VARS; j++) begin
                    if (s > 0 || w_start_acc) begin
                        r_red_lvl[s][j] <= w_red_lvl[s][j];
                        r_red_cnt[s][j] <= w_red_cnt[s][j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_REDUCE;
                    w_step_nxt  = '0;
                end
            end
            ST_REDUCE: begin
                if (r_step == c_step_last) w_state_nxt = ST_DONE;
                else                       w_step_nxt  = r_step + STEP_W'(1);
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_lvl    <= '0;
            r_clause_len <= '0;
        end else if (r_state == ST_REDUCE && r_step == c_step_last) begin
            r_max_lvl    <= r_red_lvl[RED_STAGES][0];
            r_clause_len <= r_red_cnt[RED_STAGES][0];
        end
    end

    assign find_imply_o    = r_find_imply;
    assign find_conflict_o = r_find_conflict;
    assign analyze_done_o  = (r_state == ST_DONE);
    assign busy_o          = (r_state != ST_IDLE);
    assign max_lvl_o       = r_max_lvl;
    assign clause_len_o    = r_clause_len;

endmodule
`default_nettype wire

// File: tb/tb_var_state_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_var_state_array                                              |
// | Brief    : directed scoreboard bench for var_state_array (8, 5, 1 vars)    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_var_state_array;

    typedef struct {
        string        tag;
        logic [127:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       decide_val = 1'b0;
    logic [9:0] cur_lvl = '0;
    logic       apply_imply = 1'b0;
    logic       analyze_start = 1'b0;
    logic       apply_bkt = 1'b0;
    logic [9:0] bkt_lvl = '0;

    always #5 clk = ~clk;

    // 8-var instance
    logic [23:0]  a_vv_i = '0, a_vv_o;
    logic [7:0]   a_dec = '0, a_wr = '0;
    logic [103:0] a_st_i = '0, a_st_o;
    logic         a_fi, a_fc, a_done, a_busy;
    logic [9:0]   a_max;
    logic [3:0]   a_len;
    // 5-var instance
    logic [14:0]  b_vv_i = '0, b_vv_o;
    logic [4:0]   b_dec = '0, b_wr = '0;
    logic [64:0]  b_st_i = '0, b_st_o;
    logic         b_fi, b_fc, b_done, b_busy;
    logic [9:0]   b_max;
    logic [3:0]   b_len;
    // 1-var instance
    logic [2:0]   c_vv_i = '0, c_vv_o;
    logic [0:0]   c_dec = '0, c_wr = '0;
    logic [12:0]  c_st_i = '0, c_st_o;
    logic         c_fi, c_fc, c_done, c_busy;
    logic [9:0]   c_max;
    logic [3:0]   c_len;

    var_state_array #(.NUM_VARS(8)) u_dut8 (
        .clk(clk), .rst(rst), .var_value_i(a_vv_i), .var_value_o(a_vv_o),
        .decide_i(a_dec), .decide_val_i(decide_val), .cur_lvl_i(cur_lvl),
        .apply_imply_i(apply_imply), .find_imply_o(a_fi), .find_conflict_o(a_fc),
        .analyze_start_i(analyze_start), .analyze_done_o(a_done), .max_lvl_o(a_max),
        .clause_len_o(a_len), .apply_bkt_i(apply_bkt), .bkt_lvl_i(bkt_lvl), .busy_o(a_busy),
        .wr_states_i(a_wr), .vars_states_i(a_st_i), .vars_states_o(a_st_o)
    );

    var_state_array #(.NUM_VARS(5)) u_dut5 (
        .clk(clk), .rst(rst), .var_value_i(b_vv_i), .var_value_o(b_vv_o),
        .decide_i(b_dec), .decide_val_i(decide_val), .cur_lvl_i(cur_lvl),
        .apply_imply_i(apply_imply), .find_imply_o(b_fi), .find_conflict_o(b_fc),
        .analyze_start_i(analyze_start), .analyze_done_o(b_done), .max_lvl_o(b_max),
        .clause_len_o(b_len), .apply_bkt_i(apply_bkt), .bkt_lvl_i(bkt_lvl), .busy_o(b_busy),
        .wr_states_i(b_wr), .vars_states_i(b_st_i), .vars_states_o(b_st_o)
    );

    var_state_array #(.NUM_VARS(1)) u_dut1 (
        .clk(clk), .rst(rst), .var_value_i(c_vv_i), .var_value_o(c_vv_o),
        .decide_i(c_dec), .decide_val_i(decide_val), .cur_lvl_i(cur_lvl),
        .apply_imply_i(apply_imply), .find_imply_o(c_fi), .find_conflict_o(c_fc),
        .analyze_start_i(analyze_start), .analyze_done_o(c_done), .max_lvl_o(c_max),
        .clause_len_o(c_len), .apply_bkt_i(apply_bkt), .bkt_lvl_i(bkt_lvl), .busy_o(c_busy),
        .wr_states_i(c_wr), .vars_states_i(c_st_i), .vars_states_o(c_st_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [127:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [127:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [12:0] mk(input logic [1:0] v, input logic r, input int lvl);
        return {v, r, 10'(lvl)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] v8;
        logic [64:0]  v5;
        int           n;
        bit           seen;

        tick(); tick();
        sb_push("rst_vv", '0);    check(a_vv_o);
        sb_push("rst_st", '0);    check(a_st_o);
        sb_push("rst_flags", '0); check({a_fi, a_fc, a_done, a_busy});
        sb_push("rst_result", '0); check({a_max, a_len});
        rst = 1'b0;
        tick();

        // decide var 3 true at level 5
        cur_lvl = 10'd5; decide_val = 1'b1; a_dec = 8'h08;
        sb_push("dec_v3_val", 3'b100); sb_push("dec_v3_state", mk(2'b10, 1'b0, 5));
        tick(); a_dec = '0;
        check(a_vv_o[(7-3)*3 +: 3]);
        check(a_st_o[(7-3)*13 +: 13]);

        // imply var 6 false with reason
        a_vv_i[(7-6)*3 +: 3] = 3'b011; apply_imply = 1'b1;
        sb_push("imp_v6_val", 3'b011); sb_push("imp_v6_state", mk(2'b01, 1'b1, 5));
        sb_push("imp_flags", 2'b10);
        tick(); apply_imply = 1'b0; a_vv_i = '0;
        check(a_vv_o[(7-6)*3 +: 3]);
        check(a_st_o[(7-6)*13 +: 13]);
        check({a_fi, a_fc});
        sb_push("imp_hold", 2'b10);
        tick();
        check({a_fi, a_fc});

        // opposite polarity on assigned var 3
        a_vv_i[(7-3)*3 +: 3] = 3'b010; apply_imply = 1'b1;
        sb_push("conf_flags", 2'b01); sb_push("conf_v3_kept", 3'b100);
        tick(); apply_imply = 1'b0; a_vv_i = '0;
        check({a_fi, a_fc});
        check(a_vv_o[(7-3)*3 +: 3]);

        // decide on an assigned var is ignored
        decide_val = 1'b0; a_dec = 8'h08;
        sb_push("dec_assigned", 3'b100);
        tick(); a_dec = '0;
        check(a_vv_o[(7-3)*3 +: 3]);

        // imply and decide in the same cycle: decide dropped
        decide_val = 1'b1; a_dec = 8'h01; apply_imply = 1'b1;
        sb_push("imply_beats_decide", 3'b000);
        tick(); a_dec = '0; apply_imply = 1'b0;
        check(a_vv_o[(7-0)*3 +: 3]);

        // backtrack to level 3
        v8 = '0;
        v8[(7-0)*13 +: 13] = mk(2'b10, 1'b0, 1);
        v8[(7-1)*13 +: 13] = mk(2'b10, 1'b0, 3);
        v8[(7-2)*13 +: 13] = mk(2'b01, 1'b1, 4);
        v8[(7-3)*13 +: 13] = mk(2'b10, 1'b0, 6);
        a_st_i = v8; a_wr = 8'hFF;
        sb_push("load8", v8);
        tick(); a_wr = '0;
        check(a_st_o);
        apply_bkt = 1'b1; bkt_lvl = 10'd3;
        v8[(7-2)*13 +: 13] = '0;
        v8[(7-3)*13 +: 13] = '0;
        sb_push("bkt8", v8);
        tick(); apply_bkt = 1'b0;
        check(a_st_o);

        // learned-clause reduction, 8 vars
        v8 = '0;
        v8[(7-0)*13 +: 13] = mk(2'b10, 1'b1, 2);
        v8[(7-1)*13 +: 13] = mk(2'b10, 1'b0, 5);
        v8[(7-2)*13 +: 13] = mk(2'b01, 1'b1, 4);
        v8[(7-3)*13 +: 13] = mk(2'b10, 1'b1, 5);
        v8[(7-4)*13 +: 13] = mk(2'b10, 1'b0, 3);
        a_st_i = v8; a_wr = 8'hFF;
        tick(); a_wr = '0;
        cur_lvl = 10'd5;
        a_vv_i = {3'b110, 3'b110, 3'b110, 3'b110, 12'b0};
        analyze_start = 1'b1;
        sb_push("busy8", 1'b1); sb_push("lat8", 5); sb_push("res8", {10'd4, 4'd3});
        sb_push("idle8", 2'b00);
        tick(); analyze_start = 1'b0; a_vv_i = '0; n = 1;
        check(a_busy);
        while (!a_done && n < 20) begin tick(); n++; end
        check(n);
        check({a_max, a_len});
        tick();
        check({a_done, a_busy});

        // reset two cycles into the reduction
        analyze_start = 1'b1;
        tick(); analyze_start = 1'b0;
        tick();
        rst = 1'b1;
        sb_push("midrst_vv", '0); sb_push("midrst_st", '0);
        sb_push("midrst_flags", '0); sb_push("midrst_result", '0);
        tick();
        check(a_vv_o);
        check(a_st_o);
        check({a_fi, a_fc, a_done, a_busy});
        check({a_max, a_len});
        rst = 1'b0;
        seen = 1'b0;
        sb_push("midrst_no_done", 1'b0);
        for (int i = 0; i < 8; i++) begin tick(); if (a_done) seen = 1'b1; end
        check(seen);

        // 5-var build
        v5 = '0;
        v5[(4-0)*13 +: 13] = mk(2'b10, 1'b1, 2);
        v5[(4-1)*13 +: 13] = mk(2'b10, 1'b0, 5);
        v5[(4-2)*13 +: 13] = mk(2'b01, 1'b1, 4);
        v5[(4-3)*13 +: 13] = mk(2'b10, 1'b1, 5);
        v5[(4-4)*13 +: 13] = mk(2'b10, 1'b0, 3);
        b_st_i = v5; b_wr = 5'h1F;
        tick(); b_wr = '0;
        cur_lvl = 10'd5;
        b_vv_i = {3'b110, 3'b110, 3'b110, 3'b110, 3'b000};
        analyze_start = 1'b1;
        sb_push("lat5", 5); sb_push("res5", {10'd4, 4'd3});
        tick(); analyze_start = 1'b0; b_vv_i = '0; n = 1;
        while (!b_done && n < 20) begin tick(); n++; end
        check(n);
        check({b_max, b_len});
        tick(); tick();
        b_st_i = '0; b_st_i[(4-0)*13 +: 13] = mk(2'b10, 1'b0, 9); b_wr = 5'b00001;
        apply_bkt = 1'b1; bkt_lvl = 10'd0;
        v5 = '0; v5[(4-0)*13 +: 13] = mk(2'b10, 1'b0, 9);
        sb_push("load_beats_bkt5", v5);
        tick(); b_wr = '0; apply_bkt = 1'b0;
        check(b_st_o);

        // 1-var build
        c_st_i = mk(2'b10, 1'b0, 3); c_wr = 1'b1;
        tick(); c_wr = '0;
        cur_lvl = 10'd5; c_vv_i = 3'b110; analyze_start = 1'b1;
        sb_push("lat1", 2); sb_push("res1", {10'd3, 4'd1});
        tick(); analyze_start = 1'b0; c_vv_i = '0; n = 1;
        while (!c_done && n < 20) begin tick(); n++; end
        check(n);
        check({c_max, c_len});
        tick(); tick();
        c_st_i = mk(2'b01, 1'b1, 7); c_wr = 1'b1; apply_bkt = 1'b1; bkt_lvl = 10'd0;
        sb_push("load_beats_bkt1", mk(2'b01, 1'b1, 7)); sb_push("load1_vv", 3'b011);
        tick(); c_wr = '0; apply_bkt = 1'b0;
        check(c_st_o);
        check(c_vv_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
